// File: rtl/reg_file_16x8_if.sv
// Bus bundle for reg_file_16x8: write port, read port, flat register view and the
// block-copy handshake. master = driver side (writeback path), slave = register file.
interface reg_file_16x8_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = 4;

  logic                   WE;
  logic [AW-1:0]          WA;
  logic [WIDTH-1:0]       WD;
  logic [AW-1:0]          RA;
  logic [WIDTH-1:0]       RD;
  logic [WIDTH*DEPTH-1:0] REGS;
  logic                   CP_START;
  logic [AW-1:0]          CP_SRC;
  logic [AW-1:0]          CP_DST;
  logic [AW-1:0]          CP_LEN;
  logic                   CP_BUSY;
  logic                   CP_DONE;

  modport master (
    output WE, WA, WD, RA, CP_START, CP_SRC, CP_DST, CP_LEN,
    input  RD, REGS, CP_BUSY, CP_DONE
  );

  modport slave (
    input  WE, WA, WD, RA, CP_START, CP_SRC, CP_DST, CP_LEN,
    output RD, REGS, CP_BUSY, CP_DONE
  );
endinterface

// File: rtl/reg_file_16x8.sv
// 16x8 register bank with one write port, one read port and a block-copy engine.
// Define REG_FILE_WRITE_BYPASS_EN to forward same-cycle write data onto RD.
module reg_file_16x8 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input logic           CLK,
  input logic           RST,
  reg_file_16x8_if.slave bus
);
  localparam int unsigned AW = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCopy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    src_q, src_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [AW-1:0]    last_q, last_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [AW-1:0]    rd_src;
  logic [AW-1:0]    wr_dst;
  logic             xfer;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    last_d  = last_q;
    idx_d   = idx_q;
    xfer    = 1'b0;
    rd_src  = src_q + idx_q;
    wr_dst  = dst_q + idx_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.CP_START) begin
          src_d   = bus.CP_SRC;
          dst_d   = bus.CP_DST;
          // LEN=0 wraps to 15 here, which is exactly a 16-register run.
          last_d  = bus.CP_LEN - AW'(1);
          idx_d   = '0;
          state_d = StCopy;
        end else begin
          state_d = StIdle;
        end
      end
      StCopy: begin
        // An external write steals the register write port and stalls the copy.
        if (!bus.WE) begin
          xfer  = 1'b1;
          idx_d = idx_q + AW'(1);
          if (idx_q == last_q) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    if (bus.WE) begin
      regs_d[bus.WA] = bus.WD;
    end else if (xfer) begin
      regs_d[wr_dst] = regs_q[rd_src];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bus.CP_BUSY = (state_q == StCopy);
  assign bus.CP_DONE = (state_q == StDone);

`ifdef REG_FILE_WRITE_BYPASS_EN
  assign bus.RD = (bus.WE && (bus.WA == bus.RA)) ? bus.WD : regs_q[bus.RA];
`else
  assign bus.RD = regs_q[bus.RA];
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_regs
    assign bus.REGS[WIDTH*g +: WIDTH] = regs_q[g];
  end
endmodule

// File: tb/tb_reg_file_16x8.sv
// Directed bench for reg_file_16x8: table-driven write/read vectors plus hand-written
// copy, wrap, stall, reset-abort, ignored-start and bypass sequences against a small model.
module tb_reg_file_16x8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_16x8_if bus ();

  reg_file_16x8 dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] ra;
    logic [7:0] rd;
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] mdl  [16];
  int         total = 0;
  int         bad   = 0;
  int         busy_n, done_at, done_n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = mdl[i];
    return f;
  endfunction

  task automatic model_copy(input int s, input int d, input int n);
    for (int i = 0; i < n; i++) mdl[(d + i) % 16] = mdl[(s + i) % 16];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.WE = 1'b1;
    bus.WA = a;
    bus.WD = d;
    tick();
    bus.WE = 1'b0;
    mdl[a] = d;
  endtask

  task automatic start_copy(input logic [3:0] s, input logic [3:0] d, input logic [3:0] n);
    bus.CP_SRC   = s;
    bus.CP_DST   = d;
    bus.CP_LEN   = n;
    bus.CP_START = 1'b1;
    tick();
    bus.CP_START = 1'b0;
  endtask

  // Samples each cycle after the START edge; optional external write on cycle stall_k.
  task automatic run_copy(input int stall_k, input logic [3:0] swa, input logic [7:0] swd,
                          output int b_n, output int d_at, output int d_n);
    b_n  = 0;
    d_at = 0;
    d_n  = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.CP_BUSY) b_n++;
      if (bus.CP_DONE) begin
        d_n++;
        d_at = k;
      end
      if (d_at != 0 && k > d_at + 1) break;
      if (k == stall_k) begin
        bus.WE = 1'b1;
        bus.WA = swa;
        bus.WD = swd;
      end
      tick();
      bus.WE = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'd3,  8'hA5, 4'd0,  8'h00};
    vecs[1] = '{1'b0, 4'd0,  8'h00, 4'd3,  8'hA5};
    vecs[2] = '{1'b1, 4'd5,  8'h5C, 4'd3,  8'hA5};
    vecs[3] = '{1'b1, 4'd3,  8'h17, 4'd5,  8'h5C};
    vecs[4] = '{1'b0, 4'd0,  8'h00, 4'd3,  8'h17};
    vecs[5] = '{1'b1, 4'd15, 8'hFF, 4'd4,  8'h00};
    vecs[6] = '{1'b0, 4'd0,  8'h00, 4'd15, 8'hFF};
    vecs[7] = '{1'b1, 4'd0,  8'h81, 4'd15, 8'hFF};
    vecs[8] = '{1'b0, 4'd0,  8'h00, 4'd0,  8'h81};

    bus.WE = 1'b0; bus.WA = '0; bus.WD = '0; bus.RA = '0;
    bus.CP_START = 1'b0; bus.CP_SRC = '0; bus.CP_DST = '0; bus.CP_LEN = '0;
    rst = 1'b1;
    tick();
    // Reset must win over a simultaneous write and START.
    bus.WE = 1'b1; bus.WA = 4'd1; bus.WD = 8'hFF; bus.CP_START = 1'b1;
    tick();
    bus.WE = 1'b0; bus.CP_START = 1'b0; rst = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    check("reset_regs", bus.REGS, 128'h0);
    check("reset_busy", bus.CP_BUSY, 1'b0);
    check("reset_done", bus.CP_DONE, 1'b0);

    for (int v = 0; v < 9; v++) begin
      bus.WE = vecs[v].we;
      bus.WA = vecs[v].wa;
      bus.WD = vecs[v].wd;
      bus.RA = vecs[v].ra;
      #1;
      check($sformatf("vec%0d_rd", v), bus.RD, vecs[v].rd);
      tick();
      if (vecs[v].we) mdl[vecs[v].wa] = vecs[v].wd;
    end
    bus.WE = 1'b0;
    check("vec_regs", bus.REGS, model_flat());

    // Basic 4-register copy.
    do_reset();
    wr(4'd0, 8'h11); wr(4'd1, 8'h22); wr(4'd2, 8'h33); wr(4'd3, 8'h44);
    start_copy(4'd0, 4'd8, 4'd4);
    run_copy(0, 4'd0, 8'h00, busy_n, done_at, done_n);
    model_copy(0, 8, 4);
    check("basic_busy_cycles", busy_n, 4);
    check("basic_done_cycle", done_at, 5);
    check("basic_done_count", done_n, 1);
    check("basic_dst", bus.REGS[95:64], 32'h44332211);
    check("basic_regs", bus.REGS, model_flat());

    // Wrapping, overlapping 16-register copy.
    wr(4'd14, 8'hE1); wr(4'd15, 8'hF2);
    start_copy(4'd14, 4'd2, 4'd0);
    run_copy(0, 4'd0, 8'h00, busy_n, done_at, done_n);
    model_copy(14, 2, 16);
    check("wrap_busy_cycles", busy_n, 16);
    check("wrap_done_cycle", done_at, 17);
    check("wrap_done_count", done_n, 1);
    check("wrap_reg2_5", bus.REGS[47:16], 32'h2211F2E1);
    check("wrap_reg0_1", bus.REGS[15:0], 16'h2211);
    check("wrap_regs", bus.REGS, model_flat());

    // External write stalls the copy for one cycle.
    do_reset();
    wr(4'd0, 8'hA1); wr(4'd1, 8'hB2);
    start_copy(4'd0, 4'd4, 4'd2);
    run_copy(2, 4'd9, 8'h5A, busy_n, done_at, done_n);
    mdl[9] = 8'h5A;
    model_copy(0, 4, 2);
    check("stall_busy_cycles", busy_n, 3);
    check("stall_done_cycle", done_at, 4);
    check("stall_reg9", bus.REGS[79:72], 8'h5A);
    check("stall_reg4_5", bus.REGS[47:32], 16'hB2A1);
    check("stall_regs", bus.REGS, model_flat());

    // Reset on busy cycle 3 aborts without a DONE pulse.
    for (int i = 0; i < 8; i++) wr(4'(i), 8'(8'h10 + i));
    start_copy(4'd0, 4'd8, 4'd8);
    tick();
    tick();
    check("abort_busy_before", bus.CP_BUSY, 1'b1);
    do_reset();
    check("abort_regs", bus.REGS, 128'h0);
    check("abort_busy", bus.CP_BUSY, 1'b0);
    done_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.CP_DONE || bus.CP_BUSY) done_n++;
      tick();
    end
    check("abort_no_done", done_n, 0);

    // START while busy is dropped, not queued.
    wr(4'd0, 8'hC3); wr(4'd1, 8'hD4);
    start_copy(4'd0, 4'd4, 4'd2);
    start_copy(4'd1, 4'd12, 4'd1);
    for (int k = 0; k < 5; k++) tick();
    model_copy(0, 4, 2);
    check("ignored_busy", bus.CP_BUSY, 1'b0);
    check("ignored_reg12", bus.REGS[103:96], 8'h00);
    check("ignored_regs", bus.REGS, model_flat());

    // Same-cycle write/read of one address.
    do_reset();
    bus.WE = 1'b1; bus.WA = 4'd7; bus.WD = 8'h3C; bus.RA = 4'd7;
    #1;
`ifdef REG_FILE_WRITE_BYPASS_EN
    check("bypass_rd_same", bus.RD, 8'h3C);
`else
    check("bypass_rd_same", bus.RD, 8'h00);
`endif
    check("bypass_regs_same", bus.REGS[63:56], 8'h00);
    tick();
    bus.WE = 1'b0;
    check("bypass_rd_next", bus.RD, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_16x8.md
Name: reg_file_16x8

Overview:
- 16-entry x 8-bit register bank. Its outputs drive the 16 inputs of the 16:1 operand mux directly.
- Provides one external write port and one random-access read port.
- Contains a block-copy engine that moves a run of registers to another location, one register per cycle, with a start/busy/done handshake.
- Sits directly upstream of the 16:1 operand mux. The write port is fed by the 1:4 result demux / writeback path.

Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 16, number of registers; fixed at 16, addresses are 4 bits.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- WE  input  1  external write enable.
- WA  input  4  external write address.
- WD  input  8  external write data.
- RA  input  4  read address.
- RD  output  8  read data, combinational from RA.
- REGS  output  128  flat register contents; REGS[8*i+7:8*i] = register i; wired to mux inputs I0..I15.
- CP_START  input  1  copy request; sampled only when CP_BUSY=0.
- CP_SRC  input  4  first source register.
- CP_DST  input  4  first destination register.
- CP_LEN  input  4  register count; 0 encodes 16.
- CP_BUSY  output  1  copy in progress.
- CP_DONE  output  1  one-cycle pulse when a copy completes.

Behaviour:
- Reset (RST=1 at a rising edge):
  - All 16 registers go to 8'h00.
  - FSM goes to IDLE; CP_BUSY=0, CP_DONE=0.
  - Reset wins over WE and CP_START in the same cycle.
  - Reset mid-copy aborts the copy with no CP_DONE pulse.
- External write: at the edge where WE=1, reg[WA] <= WD.
- Read:
  - RD = reg[RA], combinational.
  - A same-cycle write to RA is not visible until after the edge (unless the optional feature is enabled).
- REGS always reflects the current register contents.
- FSM states: IDLE, COPY, DONE.
  - IDLE: CP_START=1 latches SRC, DST and LEN (0 becomes 16), clears index i to 0, moves to COPY. CP_BUSY=1 from the next cycle.
  - COPY, each cycle: reg[(DST+i) mod 16] <= reg[(SRC+i) mod 16]; i <= i+1.
  - COPY exit: when i = LEN-1 the transfer still executes, then the FSM moves to DONE.
  - DONE: CP_BUSY=0, CP_DONE=1 for exactly this cycle. Next state is COPY if CP_START=1 (new operands latched), else IDLE.
- CP_START while CP_BUSY=1 is ignored; it is not queued.
- Latency: N-register copy gives CP_BUSY high for N cycles, and CP_DONE in cycle N+1 after the START edge.
- Address wrap: source and destination indices wrap modulo 16 independently (e.g. SRC=14, LEN=4 reads 14, 15, 0, 1).
- Overlap: transfers are strictly ascending; each read sees contents as updated by earlier copy cycles.
  - DST = SRC+1, LEN=3 replicates reg[SRC] into SRC+1..SRC+3.
  - SRC = DST is a legal no-op copy taking full time.
- External write during COPY:
  - WE=1 has priority. The external write is performed, the copy engine stalls that cycle (no transfer, i unchanged), and CP_BUSY stays 1.
  - Total copy time is extended by one cycle per stalled cycle.
- Copy inputs (CP_SRC, CP_DST, CP_LEN) are only sampled at an accepted START; changes during COPY have no effect.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined: RD = WD when WE=1 and WA=RA (same-cycle forwarding), otherwise reg[RA]. REGS is unaffected (never bypassed).
- Undefined: RD = reg[RA] only; written data appears the cycle after the write edge.

Test Plan:
- Reset/write/read: RST high 1 cycle → REGS=0. Write WA=3, WD=8'hA5, then RA=3 → RD=8'hA5; all other fields 0.
- Basic copy: reg0..3 = 11, 22, 33, 44; START with SRC=0, DST=8, LEN=4 → CP_BUSY high 4 cycles, CP_DONE pulse in cycle 5, reg8..11 = 11, 22, 33, 44.
- Wrap and LEN=0: SRC=14, DST=2, LEN=0 → 16 busy cycles; reg2..15 and reg0..1 equal the values originally in reg14, 15, 0, 1.. with ascending overlap semantics, checked against a reference model; CP_DONE once.
- Stall priority: copy LEN=2 (SRC=0, DST=4); WE=1 on 2nd busy cycle to WA=9, WD=8'h5A → reg9=5A, copy takes 3 busy cycles, reg4..5 correct.
- Reset mid-copy and START while busy: start LEN=8, assert RST on busy cycle 3 → all registers 0, CP_BUSY=0, no CP_DONE. Separately, a second START while busy is ignored (destination unchanged).
- Bypass: WE=1, WA=RA=7, WD=8'h3C, reg7=0 → RD=3C with macro defined, 00 without; both builds see 3C next cycle.
